// File: rtl/mmio_io_ctrl_pkg.sv
// Register indices and STATUS/CTRL bit positions for the MMIO switch/LED controller.
package mmio_io_pkg;
  localparam int REG_STATUS  = 0;
  localparam int REG_LED     = 1;
  localparam int REG_CTRL    = 2;
  localparam int REG_SW_BASE = 3;

  localparam int STAT_LED_DONE = 0;
  localparam int STAT_SW_VALID = 1;
  localparam int STAT_SW_OVR   = 2;

  localparam int CTRL_AUTO_COMMIT = 0;
  localparam int CTRL_IRQ_EN      = 1;

  function automatic int byte_count(input int width);
    return (width + 7) / 8;
  endfunction
endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU-side MMIO bus: single-cycle read/write strobes, registered read data.
interface mmio_io_ctrl_if #(
  parameter int ADDR_W = 3
) ();
  logic              pRead;
  logic              pWrite;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       pWriteData;
  logic [31:0]       pReadData;

  modport master (output pRead, pWrite, addr, pWriteData, input pReadData);
  modport slave  (input pRead, pWrite, addr, pWriteData, output pReadData);
endinterface

// File: rtl/mmio_io_ctrl_debounce.sv
// Button debouncer: 2-FF synchroniser, stability counter, one-cycle press pulse.
// Level flips D+2 edges after the input first samples high; press is high the cycle after.
// No backpressure: press is a fire-and-forget pulse.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= ~level;
        press <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO switch/LED controller with debounced commit/capture buttons, status flags and irq.
// Reads and writes take effect at the strobe edge; no backpressure on the CPU bus.
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 12,
  parameter int ADDR_W          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_io_ctrl_if.slave        bus,
  input  logic                 buttonL,
  input  logic                 buttonR,
  input  logic [SW_WIDTH-1:0]  switch,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq
);
  localparam int SW_BYTES = byte_count(SW_WIDTH);

  if (REG_SW_BASE + SW_BYTES > 2**ADDR_W) begin : g_addr_chk
    $error("ADDR_W too small for SW_WIDTH");
  end
  if (LED_WIDTH < 1 || LED_WIDTH > 32) begin : g_led_chk
    $error("LED_WIDTH must be 1..32");
  end

  logic                 press_l, press_r;
  logic                 lvl_l_unused, lvl_r_unused;
  logic [LED_WIDTH-1:0] staged;
  logic [SW_WIDTH-1:0]  capture;
  logic [SW_BYTES*8-1:0] cap_pad;
  logic                 led_done, sw_valid, sw_ovr, auto_commit, irq_en;
  logic                 wr_led, wr_ctrl, wr_stat, sw_rd_clr;
  logic                 sw_valid_n, irq_en_n;
  logic [31:0]          rdata;
  logic                 unused_wdata;

  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk(clk), .reset(reset), .raw(buttonL), .level(lvl_l_unused), .press(press_l)
  );
  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(clk), .reset(reset), .raw(buttonR), .level(lvl_r_unused), .press(press_r)
  );

  assign unused_wdata = ^bus.pWriteData;
  assign cap_pad   = (SW_BYTES*8)'(capture);
  assign wr_led    = bus.pWrite && (bus.addr == ADDR_W'(REG_LED));
  assign wr_ctrl   = bus.pWrite && (bus.addr == ADDR_W'(REG_CTRL));
  assign wr_stat   = bus.pWrite && (bus.addr == ADDR_W'(REG_STATUS));
  assign sw_rd_clr = bus.pRead  && (bus.addr == ADDR_W'(REG_SW_BASE + SW_BYTES - 1));

  // A capture in the same cycle as the clearing read keeps SW_VALID set.
  assign sw_valid_n = press_r ? 1'b1 : (sw_rd_clr ? 1'b0 : sw_valid);
  assign irq_en_n   = wr_ctrl ? bus.pWriteData[CTRL_IRQ_EN] : irq_en;

  always_comb begin
    rdata = '0;
    if (bus.addr == ADDR_W'(REG_STATUS)) begin
      rdata[STAT_LED_DONE] = led_done;
      rdata[STAT_SW_VALID] = sw_valid;
      rdata[STAT_SW_OVR]   = sw_ovr;
    end else if (bus.addr == ADDR_W'(REG_LED)) begin
      rdata = 32'(staged);
    end else if (bus.addr == ADDR_W'(REG_CTRL)) begin
      rdata[CTRL_AUTO_COMMIT] = auto_commit;
      rdata[CTRL_IRQ_EN]      = irq_en;
    end
    for (int i = 0; i < SW_BYTES; i++) begin
      if (bus.addr == ADDR_W'(REG_SW_BASE + i)) rdata = {24'b0, cap_pad[i*8 +: 8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.pReadData <= '0;
      led           <= '0;
      staged        <= '0;
      capture       <= '0;
      led_done      <= 1'b0;
      sw_valid      <= 1'b0;
      sw_ovr        <= 1'b0;
      auto_commit   <= 1'b0;
      irq_en        <= 1'b0;
      irq           <= 1'b0;
    end else begin
      if (bus.pRead) bus.pReadData <= rdata;

      // Commit first so a same-cycle LED_DATA write overrides staged/LED_DONE.
      if (press_l) begin
        led      <= staged;
        led_done <= 1'b1;
      end
      if (wr_led) begin
        staged <= bus.pWriteData[LED_WIDTH-1:0];
        if (auto_commit) begin
          led      <= bus.pWriteData[LED_WIDTH-1:0];
          led_done <= 1'b1;
        end else begin
          led_done <= 1'b0;
        end
      end

      if (wr_ctrl) begin
        auto_commit <= bus.pWriteData[CTRL_AUTO_COMMIT];
        irq_en      <= bus.pWriteData[CTRL_IRQ_EN];
      end

      if (press_r) capture <= switch;
      sw_valid <= sw_valid_n;
      if (press_r && sw_valid && !sw_rd_clr) sw_ovr <= 1'b1;
      else if (wr_stat && bus.pWriteData[STAT_SW_OVR]) sw_ovr <= 1'b0;

      irq <= sw_valid_n & irq_en_n;
    end
  end
endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Parametrised memory-mapped I/O controller on the multi-cycle MIPS data bus, the successor to the fixed 2-bit-address switch/LED port. It adds configurable switch and LED widths, on-chip debouncing with single-event edge detection for both buttons, and a control register for auto-commit LED mode and an interrupt. It adds clear-on-read and overrun status flags and gives the CPU read port registered timing.

Parameters:
SW_WIDTH, 16, switch bank width; SW_BYTES = ceil(SW_WIDTH/8) byte registers.
LED_WIDTH, 12, LED bank width, 1..32.
ADDR_W, 3, register address width; 3+SW_BYTES <= 2**ADDR_W is required (elaboration-time assert).
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a button level is accepted; benches use 4.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (0 = reset)
pRead  in  1  CPU read strobe, single cycle
pWrite  in  1  CPU write strobe, single cycle
addr  in  ADDR_W  register index
pWriteData  in  32  write data
pReadData  out  32  read data, registered
buttonL  in  1  raw asynchronous LED-commit button
buttonR  in  1  raw asynchronous switch-capture button
switch  in  SW_WIDTH  raw switch bank
led  out  LED_WIDTH  LED drive
irq  out  1  interrupt request, level

Behaviour:
- Reset (reset==0 at posedge): led, pReadData, irq, staged LED, switch capture, CTRL and STATUS go to 0. Debounce synchronisers, counters and levels also go to 0. Reset mid-debounce discards the partial count.
- Register map:
  - 0 STATUS: bit0 LED_DONE, bit1 SW_VALID, bit2 SW_OVERRUN; other bits read 0.
  - 1 LED_DATA (R/W staged value).
  - 2 CTRL: bit0 AUTO_COMMIT, bit1 IRQ_EN.
  - 3..3+SW_BYTES-1: captured switch bytes, low byte first, zero-extended to 32 bits; bits above SW_WIDTH read 0.
  - Unmapped addresses read 0; writes to them and to switch bytes are ignored.
- Read: pRead sampled at edge k loads pReadData at edge k; it holds until the next read. No read leaves it unchanged.
- Write LED_DATA: the staged value becomes pWriteData[LED_WIDTH-1:0] and LED_DONE is cleared. If AUTO_COMMIT=1, led also updates at the same edge and LED_DONE is set instead.
- Write STATUS: writing 1 to bit2 clears SW_OVERRUN. Bits 0 and 1 are not writable.
- Button debounce, per button:
  - 2-FF synchroniser feeds a counter that increments while the synchronised value differs from the debounced level and clears when they match.
  - The level flips when the count reaches DEBOUNCE_CYCLES.
  - A press event is a one-cycle pulse on the rising edge of the level.
  - If the input first samples high at edge 1 and stays high, the level flips at edge D+2 and the action commits at edge D+3.
  - Glitches shorter than D cycles produce no event. Release produces no event.
- buttonL event: led <= staged value; LED_DONE <= 1.
- buttonR event: capture <= switch; SW_VALID <= 1. SW_OVERRUN <= 1 if SW_VALID was already 1 and is not being cleared in the same cycle.
- Reading the highest switch byte (addr 3+SW_BYTES-1) clears SW_VALID.
- Simultaneous events:
  - buttonR capture with a clearing read in the same cycle: the capture wins. The read returns the old byte, SW_VALID stays 1, and no overrun is flagged.
  - buttonL event with an LED_DATA write in the same cycle: led gets the old staged value, LED_DONE ends 0, and the staged value takes the new data. With AUTO_COMMIT=1, the write value wins on led and LED_DONE=1.
  - pRead and pWrite to the same register in the same cycle: the read returns the pre-write value.
- irq = SW_VALID & IRQ_EN, driven from registers (glitch-free). It deasserts the edge after the clearing read or the IRQ_EN=0 write.

Decomposition:
- Package mmio_io_pkg holds the register index constants (REG_STATUS=0, REG_LED=1, REG_CTRL=2, REG_SW_BASE=3) and the STATUS/CTRL bit-position constants.
- Sub-module io_debounce (params DEBOUNCE_CYCLES; ports clk, reset, raw, level, press), instantiated once per button.

Test Plan:
1. Reset and basic read: hold reset=0 for 3 cycles, then release. Reading addrs 0..7 returns 0; led=0, irq=0.
2. LED commit (D=4): write 0xABC to addr 1; STATUS reads 0x0. Hold buttonL high 10 cycles; led=0xABC exactly at edge 7 after the first sampling edge, and STATUS bit0=1. A 3-cycle buttonL pulse leaves led unchanged.
3. Auto-commit: write CTRL=1, then write 0x5A5 to addr 1. led=0x5A5 at the write edge; STATUS=0x1 with no button press.
4. Switch capture with irq: CTRL=2, switch=0xBEEF, press buttonR. irq=1, STATUS=0x2; addr 3 reads 0xEF. Reading addr 4 returns 0xBE and the next STATUS read is 0x0 with irq=0.
5. Overrun: two buttonR presses (switch 0x1234 then 0x5678) with no read. STATUS=0x6 and addr 3 reads 0x78. Writing 0x4 to STATUS makes it read 0x2.
6. Collision: a buttonR event lands on the same edge as a read of addr 4. The read returns the old high byte, SW_VALID stays 1, and SW_OVERRUN stays 0.
